// File: rtl/fmul_pkg.sv
// fmul_pkg: shared types for the FP32 multiplier issue/collect stage.
//   state_t : controller states (IDLE, ISSUE, DRAIN)
//   tag_t   : per-slot tag carried alongside the multiplier pipeline
package fmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/prod_fifo.sv
// prod_fifo: synchronous FIFO holding multiplier products plus their
// last flag. The head entry is read from registered storage, so data
// written on one edge becomes visible at the head after that edge.
// Ports:
//   clk, reset (async, active-high)
//   push, push_data : write one entry (ignored when full)
//   pop             : remove the head entry (ignored when empty)
//   head, valid     : current head entry and its valid flag
//   count           : number of stored entries (0..DEPTH)
module prod_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & (count != (PTR_W+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fmul_issue_ctrl.sv
// fmul_issue_ctrl: walks the weight and input RAMs for `len` elements,
// feeds each operand pair to an external FP32 multiplier, tracks the
// multiplier latency with a tag pipe and collects products in a FIFO.
// Issue is credit-limited (in-flight + buffered < FIFO_DEPTH) so no
// product is ever dropped while the consumer stalls.
// Ports:
//   clk, reset (async, active-high)
//   start, len, w_base, x_base : command (sampled only in IDLE)
//   busy, done                 : status; done pulses once per command
//   w_addr, x_addr, rd_en      : RAM read port (1-cycle read latency)
//   w_rdata, x_rdata           : RAM read data
//   mul_clken, mul_a, mul_b    : multiplier enable and operands
//   mul_p                      : multiplier product (MUL_LAT enabled cycles later)
//   prod_valid/data/last/ready : product output handshake
module fmul_issue_ctrl
  import fmul_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MUL_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic              rd_en,
  input  logic [31:0]       w_rdata,
  input  logic [31:0]       x_rdata,
  output logic              mul_clken,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_p,
  output logic              prod_valid,
  output logic [31:0]       prod_data,
  output logic              prod_last,
  input  logic              prod_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] x_ptr;
  logic [ADDR_W:0]   remaining;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  fifo_count;
  logic              zero_done;
  tag_t              tag_pipe [MUL_LAT+1];
  logic [32:0]       fifo_head;

  logic accept;
  logic zero_cmd;
  logic credit_ok;
  logic issue;
  logic last_issue;
  logic push;
  logic push_last;

  assign accept     = (state == IDLE) & start & (len != {(ADDR_W+1){1'b0}});
  assign zero_cmd   = (state == IDLE) & start & (len == {(ADDR_W+1){1'b0}});
  // Credits cover both products still in the RAM/multiplier path and those already buffered.
  assign credit_ok  = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = (state == ISSUE) & credit_ok;
  assign last_issue = issue & (remaining == (ADDR_W+1)'(1));
  // Stage 0 is the RAM read cycle; stages 1..MUL_LAT follow the multiplier.
  assign push       = tag_pipe[MUL_LAT].valid;
  assign push_last  = push & tag_pipe[MUL_LAT].last;

  assign busy       = (state != IDLE);
  assign done       = zero_done | push_last;
  assign rd_en      = issue;
  assign w_addr     = w_ptr;
  assign x_addr     = x_ptr;
  assign mul_clken  = busy;
  assign mul_a      = w_rdata;
  assign mul_b      = x_rdata;
  assign prod_data  = fifo_head[31:0];
  assign prod_last  = fifo_head[32];

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE; else state_nxt = IDLE;
      ISSUE:   if (last_issue) state_nxt = DRAIN; else state_nxt = ISSUE;
      DRAIN:   if (push_last) state_nxt = IDLE; else state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, address/length counters and zero-length completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      w_ptr     <= '0;
      x_ptr     <= '0;
      remaining <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_done <= zero_cmd;
      if (accept) begin
        w_ptr     <= w_base;
        x_ptr     <= x_base;
        remaining <= len;
      end else if (issue) begin
        w_ptr     <= w_ptr + ADDR_W'(1);
        x_ptr     <= x_ptr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  // Elements issued but not yet pushed into the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({issue, push})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Tag pipe advances in lockstep with the multiplier enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= MUL_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else if (busy) begin
      tag_pipe[0].valid <= issue;
      tag_pipe[0].last  <= last_issue;
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  prod_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (33)
  ) u_prod_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_last, mul_p}),
    .pop       (prod_ready),
    .head      (fifo_head),
    .valid     (prod_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// tb_fmul_issue_ctrl: directed bench for fmul_issue_ctrl with behavioural
// weight/input RAMs and a MUL_LAT-deep FP32 multiplier model.
module tb_fmul_issue_ctrl;

  localparam int ADDR_W  = 8;
  localparam int MUL_LAT = 4;
  localparam int DEPTH   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] w_base, x_base;
  logic              busy, done, rd_en, mul_clken;
  logic [ADDR_W-1:0] w_addr, x_addr;
  logic [31:0]       w_rdata, x_rdata, mul_a, mul_b, mul_p;
  logic              prod_valid, prod_last, prod_ready;
  logic [31:0]       prod_data;

  fmul_issue_ctrl #(.ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .w_base(w_base), .x_base(x_base),
    .busy(busy), .done(done), .w_addr(w_addr), .x_addr(x_addr), .rd_en(rd_en),
    .w_rdata(w_rdata), .x_rdata(x_rdata), .mul_clken(mul_clken), .mul_a(mul_a),
    .mul_b(mul_b), .mul_p(mul_p), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(prod_ready)
  );

  always #5 clk = ~clk;

  // Exact FP32 multiply for normal operands whose product needs no rounding.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  logic [31:0] w_mem [256];
  logic [31:0] x_mem [256];
  logic [31:0] mpipe [MUL_LAT];

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      w_rdata <= w_mem[w_addr];
      x_rdata <= x_mem[x_addr];
    end
  end

  // Multiplier model: MUL_LAT enabled cycles from operands to product.
  always @(posedge clk) begin
    if (mul_clken) begin
      mpipe[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_p = mpipe[MUL_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor (samples on the falling edge).
  int          n_rd, n_done, n_busy, first_rd, first_valid, done_cyc;
  logic [31:0] data_q [$];
  logic        last_q [$];
  logic [7:0]  waddr_q [$];
  always @(negedge clk) begin
    if (rd_en) begin
      n_rd = n_rd + 1;
      waddr_q.push_back(w_addr);
      if (first_rd < 0) first_rd = cyc;
    end
    if (busy) n_busy = n_busy + 1;
    if (done) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
    if (prod_valid && first_valid < 0) first_valid = cyc;
    if (prod_valid && prod_ready) begin
      data_q.push_back(prod_data);
      last_q.push_back(prod_last);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int t0;
  logic [31:0] w_exp [20];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    n_rd = 0; n_done = 0; n_busy = 0; first_rd = -1; first_valid = -1; done_cyc = -1;
    data_q.delete(); last_q.delete(); waddr_q.delete();
  endtask

  task automatic start_cmd(input int l, input logic [7:0] wb, input logic [7:0] xb);
    len = (ADDR_W+1)'(l); w_base = wb; x_base = xb; start = 1'b1;
    t0 = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_cmd(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (data_q.size() >= n && !busy) break;
      step(1);
    end
    check("product_count", 32'(data_q.size()), 32'(n));
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_clken", 32'(mul_clken), 32'd0);
    check("rst_valid", 32'(prod_valid), 32'd0);
    check("rst_last", 32'(prod_last), 32'd0);
    check("rst_waddr", 32'(w_addr), 32'd0);
    check("rst_xaddr", 32'(x_addr), 32'd0);
    check("rst_data", prod_data, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prod_ready = 1'b1;
    len = '0; w_base = '0; x_base = '0;
    for (int i = 0; i < 256; i++) begin
      w_mem[i] = 32'd0;
      x_mem[i] = 32'h3F800000;
    end
    for (int i = 0; i < 20; i++) begin
      w_exp[i] = 32'h3F800000 + 32'(i) * 32'h00012345;
      w_mem[8'h40 + i] = w_exp[i];
    end
    w_mem[8'h10] = 32'h3F800000; w_mem[8'h11] = 32'h40000000;
    w_mem[8'h12] = 32'h40400000; w_mem[8'h13] = 32'h40800000;
    x_mem[8'h20] = 32'h40000000; x_mem[8'h21] = 32'h40000000;
    x_mem[8'h22] = 32'h40000000; x_mem[8'h23] = 32'h3F000000;
    w_mem[8'hFE] = 32'h41000000; w_mem[8'hFF] = 32'h41100000;
    w_mem[8'h00] = 32'h41200000; w_mem[8'h01] = 32'h41300000;
    clear_mon();
    step(2);
    check_reset_outputs();
    reset = 1'b0;
    step(1);

    // Basic 4-element command with latency checks.
    clear_mon();
    start_cmd(4, 8'h10, 8'h20);
    wait_cmd(4, 60);
    step(2);
    check("first_rd_cyc", 32'(first_rd), 32'(t0 + 1));
    check("first_valid_cyc", 32'(first_valid), 32'(t0 + 3 + MUL_LAT));
    check("done_cyc", 32'(done_cyc), 32'(t0 + 5 + MUL_LAT));
    check("done_count", 32'(n_done), 32'd1);
    if (data_q.size() == 4) begin
      check("p0", data_q[0], 32'h40000000);
      check("p1", data_q[1], 32'h40800000);
      check("p2", data_q[2], 32'h40C00000);
      check("p3", data_q[3], 32'h40000000);
      check("last_bits", 32'({last_q[0], last_q[1], last_q[2], last_q[3]}), 32'b0001);
    end

    // Zero-length command.
    clear_mon();
    start_cmd(0, 8'h10, 8'h20);
    step(4);
    check("len0_done", 32'(n_done), 32'd1);
    check("len0_done_cyc", 32'(done_cyc), 32'(t0 + 1));
    check("len0_rd", 32'(n_rd), 32'd0);
    check("len0_busy", 32'(n_busy), 32'd0);

    // Stalled consumer: credits stop issue at FIFO_DEPTH.
    prod_ready = 1'b0;
    clear_mon();
    start_cmd(20, 8'h40, 8'h80);
    step(30);
    check("stall_rd_count", 32'(n_rd), 32'(DEPTH));
    check("stall_valid", 32'(prod_valid), 32'd1);
    check("stall_data", prod_data, w_exp[0]);
    check("stall_busy", 32'(busy), 32'd1);
    step(5);
    check("stall_rd_hold", 32'(n_rd), 32'(DEPTH));
    check("stall_data_hold", prod_data, w_exp[0]);
    check("stall_last", 32'(prod_last), 32'd0);
    prod_ready = 1'b1;
    wait_cmd(20, 200);
    step(2);
    check("stall_total", 32'(data_q.size()), 32'd20);
    if (data_q.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("stall_p%0d", i), data_q[i], w_exp[i]);
        check($sformatf("stall_l%0d", i), 32'(last_q[i]), 32'(i == 19));
      end
    end
    check("stall_done", 32'(n_done), 32'd1);

    // Address wrap.
    clear_mon();
    start_cmd(4, 8'hFE, 8'h05);
    wait_cmd(4, 60);
    if (waddr_q.size() == 4) begin
      check("wrap_a0", 32'(waddr_q[0]), 32'h0FE);
      check("wrap_a1", 32'(waddr_q[1]), 32'h0FF);
      check("wrap_a2", 32'(waddr_q[2]), 32'h000);
      check("wrap_a3", 32'(waddr_q[3]), 32'h001);
    end else begin
      check("wrap_rd_count", 32'(waddr_q.size()), 32'd4);
    end
    if (data_q.size() == 4) begin
      check("wrap_p0", data_q[0], 32'h41000000);
      check("wrap_p3", data_q[3], 32'h41300000);
    end

    // Reset in the middle of ISSUE.
    clear_mon();
    start_cmd(10, 8'h40, 8'h80);
    for (int k = 0; k < 20 && n_rd < 3; k++) step(1);
    check("pre_reset_rd", 32'(n_rd), 32'd3);
    reset = 1'b1;
    step(1);
    check_reset_outputs();
    reset = 1'b0;
    step(3);
    check("post_reset_valid", 32'(prod_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    clear_mon();
    start_cmd(2, 8'h40, 8'h80);
    wait_cmd(2, 40);
    if (data_q.size() == 2) begin
      check("after_rst_p0", data_q[0], w_exp[0]);
      check("after_rst_p1", data_q[1], w_exp[1]);
      check("after_rst_last", 32'({last_q[0], last_q[1]}), 32'b01);
    end
    check("after_rst_done", 32'(n_done), 32'd1);

    // start pulses while busy must be ignored.
    clear_mon();
    start_cmd(5, 8'h40, 8'h80);
    step(2);
    len = 9'd3; start = 1'b1; step(1); start = 1'b0;
    step(3);
    start = 1'b1; step(1); start = 1'b0;
    wait_cmd(5, 60);
    step(10);
    check("busy_start_count", 32'(data_q.size()), 32'd5);
    check("busy_start_done", 32'(n_done), 32'd1);
    check("busy_start_rd", 32'(n_rd), 32'd5);
    if (data_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("busy_start_p%0d", i), data_q[i], w_exp[i]);
      check("busy_start_last", 32'(last_q[4]), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fmul_issue_ctrl.md
# fmul_issue_ctrl

Operand issue and product collection stage placed directly upstream and downstream of the FP32 multiplier in the LSTM datapath. On a start command it walks two synchronous RAMs, the weight RAM and the input RAM, for `len` elements. It presents each operand pair to the multiplier, tracks the multiplier's fixed pipeline latency with valid tags, and buffers the returned products in a small FIFO with a valid/ready output. Issue is credit-limited, so a product is never dropped when the consumer stalls.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM address width; `len` is also ADDR_W+1 bits wide so a full RAM can be walked.
- `MUL_LAT`, default 4: multiplier latency in enabled cycles, counted from operands at `mul_a`/`mul_b` to the product at `mul_p`; minimum 1.
- `FIFO_DEPTH`, default 8: product FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `len`, in, ADDR_W+1: element count.
- `w_base`, in, ADDR_W: weight RAM start address.
- `x_base`, in, ADDR_W: input RAM start address.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse at command completion.
- `w_addr`, out, ADDR_W: weight RAM address.
- `x_addr`, out, ADDR_W: input RAM address.
- `rd_en`, out, 1: read strobe to both RAMs, which have 1-cycle read latency.
- `w_rdata`, in, 32: weight RAM read data.
- `x_rdata`, in, 32: input RAM read data.
- `mul_clken`, out, 1: multiplier clock enable.
- `mul_a`, out, 32: multiplier operand A.
- `mul_b`, out, 32: multiplier operand B.
- `mul_p`, in, 32: multiplier product.
- `prod_valid`, out, 1: FIFO head valid.
- `prod_data`, out, 32: FIFO head product.
- `prod_last`, out, 1: FIFO head is the final product of the command.
- `prod_ready`, in, 1: consumer accepts the head.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE + `start`:
  - If `len`==0: `done` pulses the next cycle; stay in IDLE; no reads, no products.
  - Otherwise latch `len`, `w_base` and `x_base` into counters and go to ISSUE.
- ISSUE: each cycle, issue one element if `in_flight + fifo_count < FIFO_DEPTH`.
  - Issuing means: `rd_en`=1; `w_addr`/`x_addr` = current pointers; pointers increment with wrap modulo 2^ADDR_W; remaining count decrements.
  - Otherwise insert a bubble (`rd_en`=0).
  - When the last element is issued, go to DRAIN.
- `mul_a`/`mul_b` are driven directly from `w_rdata`/`x_rdata`.
- Tag pipe: a {valid, last} bit pair is shifted in one cycle after each read, through a MUL_LAT-stage shift register. A bubble shifts in a zero tag.
- `mul_clken` = `busy`, so the multiplier pipeline advances every cycle while busy and is frozen in IDLE.
- Tag pipe output valid: `mul_p` and the tag's last bit are pushed into the FIFO. A push is always possible because of the credit rule.
- `in_flight` counts issued elements whose product is not yet pushed. This includes the RAM read cycle.
- DRAIN: when the tag with last=1 is pushed, `done` pulses in that cycle and the state returns to IDLE. The FIFO may still hold products, which are drained through the handshake independently.
- FIFO: a pop happens when `prod_valid & prod_ready`. A simultaneous push and pop leaves the count unchanged. Data is held stable while valid and not ready.
- `start` is ignored while busy.
- A new `start` in IDLE is accepted even if the FIFO still holds products; credits account for them.
- Reset, including mid-command: state IDLE, counters and tag pipe cleared, FIFO emptied.
  - Outputs after reset: `busy`=0, `done`=0, `rd_en`=0, `mul_clken`=0, `prod_valid`=0, `prod_last`=0, addresses 0, `prod_data`=0.

## Timing
- Start is sampled at cycle T. The first `rd_en` is at T+1 when credit is available. Operands are at `mul_a`/`mul_b` at T+2. The product is pushed at T+2+MUL_LAT. `prod_valid` is high at T+3+MUL_LAT, because the FIFO output is registered.
- With no stalls, throughput is one product per cycle. The maximum sustained issue rate is bounded by FIFO_DEPTH credits.
- `done` is asserted in the same cycle as the push of the last product.

## Structure
- Package `fmul_pkg` holds the state enum (IDLE/ISSUE/DRAIN) and the tag struct {valid, last}.
- One sub-module, `prod_fifo`: a synchronous FIFO carrying 33-bit entries (data + last) with a `count` output.
- The multiplier itself is instantiated by the parent, not inside this block.

## Test plan
- len=4, w=[1.0,2.0,3.0,4.0], x=[2.0,2.0,2.0,0.5], `prod_ready`=1 → products 0x40000000, 0x40800000, 0x40C00000, 0x40000000. `prod_last` is set on the 4th only. `done` pulses once.
- len=0 → `done` at T+1, `busy` stays 0, `rd_en` never asserts.
- len=20 with `prod_ready`=0 → after 8 issues `rd_en` stays 0 and `prod_valid` is held. Releasing ready → all 20 products arrive in order, none lost or duplicated.
- w_base=0xFE, len=4 → `w_addr` sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset asserted mid-ISSUE after 3 issues → next cycle all outputs are at reset values and the FIFO is empty. A following len=2 command completes correctly.
- `start` pulsed while busy → ignored; exactly one `done` and `len` products are produced.
